// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, funct values,
// the mul/div FSM state type and small arithmetic helpers.
package ex_pkg;

    localparam int DATA_W = 32;

    // aluOp encodings from ID/EX
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    // funct field values (signExtendWire[5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_MFHI = 4'd5,
        ALU_MFLO = 4'd6,
        ALU_MULT = 4'd7,
        ALU_DIV  = 4'd8
    } alu_fn_e;

    // Unsigned magnitude of a two's-complement word (0x80000000 stays 2^31).
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    // Collapse aluOp/funct into a single internal ALU function.
    function automatic alu_fn_e decode_alu(input logic [1:0] op, input logic [5:0] fn);
        alu_fn_e r;
        r = ALU_ADD;
        case (op)
            ALUOP_ADD, ALUOP_ADD2: r = ALU_ADD;
            ALUOP_SUB:             r = ALU_SUB;
            ALUOP_FUNCT: begin
                case (fn)
                    FN_ADD:  r = ALU_ADD;
                    FN_SUB:  r = ALU_SUB;
                    FN_AND:  r = ALU_AND;
                    FN_OR:   r = ALU_OR;
                    FN_SLT:  r = ALU_SLT;
                    FN_MULT: r = ALU_MULT;
                    FN_DIV:  r = ALU_DIV;
                    FN_MFHI: r = ALU_MFHI;
                    FN_MFLO: r = ALU_MFLO;
                    default: r = ALU_ADD;
                endcase
            end
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_stage_mul_div.sv
// Iterative signed multiply/divide unit: 32 shift-add or restoring-divide
// steps on operand magnitudes, sign fix-up in DONE, result into HI/LO.
module mul_div_unit
    import ex_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start_mul_i,
    input  logic              start_div_i,
    input  logic [DATA_W-1:0] op_a_i,
    input  logic [DATA_W-1:0] op_b_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_e           state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, lo_q;

    // Working registers; only meaningful while the FSM is out of IDLE.
    logic                div_q, neg_a_q, neg_res_q, dvz_q;
    logic [DATA_W-1:0]   dividend_q;
    logic [2*DATA_W-1:0] acc_q, mcand_q;
    logic [DATA_W-1:0]   opb_q, quo_q, rem_q;

    logic [DATA_W:0]     shifted, diff;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   hi_fin, lo_fin;

    // State and iteration counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: 32 iterations in MUL/DIV, one fix-up cycle in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                cnt_d = '0;
                if (start_mul_i)      state_d = MD_MUL;
                else if (start_div_i) state_d = MD_DIV;
            end
            MD_MUL, MD_DIV: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = MD_DONE;
                    cnt_d   = '0;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // One restoring-division step: shift in next dividend bit, try subtract
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, opb_q};
    end

    // Datapath: latch magnitudes on issue, then iterate
    always_ff @(posedge clock) begin
        case (state_q)
            MD_IDLE: begin
                if (start_mul_i || start_div_i) begin
                    div_q      <= start_div_i && !start_mul_i;
                    neg_a_q    <= op_a_i[DATA_W-1];
                    neg_res_q  <= op_a_i[DATA_W-1] ^ op_b_i[DATA_W-1];
                    dvz_q      <= (op_b_i == '0);
                    dividend_q <= op_a_i;
                    acc_q      <= '0;
                    mcand_q    <= {{DATA_W{1'b0}}, mag(op_a_i)};
                    opb_q      <= mag(op_b_i);
                    quo_q      <= mag(op_a_i);
                    rem_q      <= '0;
                end
            end
            MD_MUL: begin
                if (opb_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q <= mcand_q << 1;
                opb_q   <= opb_q >> 1;
            end
            MD_DIV: begin
                if (!diff[DATA_W]) begin
                    rem_q <= diff[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[DATA_W-1:0];
                    quo_q <= {quo_q[DATA_W-2:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Sign fix-up of the finished magnitudes, including divide-by-zero
    always_comb begin
        prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
        if (div_q) begin
            if (dvz_q) begin
                lo_fin = '1;
                hi_fin = dividend_q;
            end else begin
                lo_fin = neg_res_q ? (~quo_q + 1'b1) : quo_q;
                hi_fin = neg_a_q   ? (~rem_q + 1'b1) : rem_q;
            end
        end else begin
            hi_fin = prod[2*DATA_W-1:DATA_W];
            lo_fin = prod[DATA_W-1:0];
        end
    end

    // HI/LO commit in DONE; reset clears them (aborted ops leave zeros)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == MD_DONE) begin
            hi_q <= hi_fin;
            lo_q <= lo_fin;
        end
    end

    assign busy_o = (state_q != MD_IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, EX/MEM register,
// and the multi-cycle mul/div unit that stalls the pipeline.
module ex_stage
    import ex_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              regDest,
    input  logic              aluSrc,
    input  logic [1:0]        aluOp,
    input  logic [2:0]        memControlInput,
    input  logic [1:0]        wbControlInput,
    input  logic [DATA_W-1:0] readData1,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] signExtendWire,
    input  logic [4:0]        rd,
    input  logic [4:0]        rt,
    input  logic [4:0]        rs,
    input  logic              exMemRegWrite,
    input  logic [4:0]        exMemRd,
    input  logic [DATA_W-1:0] exMemAluFwd,
    input  logic              memWbRegWrite,
    input  logic [4:0]        memWbRd,
    input  logic [DATA_W-1:0] memWbData,
    output logic [DATA_W-1:0] aluResult,
    output logic [DATA_W-1:0] writeData,
    output logic [4:0]        writeReg,
    output logic [2:0]        memControlExMem,
    output logic [1:0]        wbControlExMem,
    output logic              stall
);

    logic [DATA_W-1:0]        op_a, fwd_b, op_b, hi, lo;
    logic signed [DATA_W-1:0] sa, sb;
    logic [DATA_W-1:0]        alu_res;
    alu_fn_e                  fn;
    logic                     issue, is_md, bubble, start_mul, start_div;

    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [2:0]        mem_ctl_q, mem_ctl_d;
    logic [1:0]        wb_ctl_q, wb_ctl_d;

    // Youngest producer wins; register 0 is never forwarded.
    function automatic logic [DATA_W-1:0] fwd(input logic [4:0] src,
                                              input logic [DATA_W-1:0] rf_val);
        if (exMemRegWrite && exMemRd == src && src != 5'd0)
            return exMemAluFwd;
        else if (memWbRegWrite && memWbRd == src && src != 5'd0)
            return memWbData;
        else
            return rf_val;
    endfunction

    // Operand selection with forwarding and immediate mux
    always_comb begin
        op_a  = fwd(rs, readData1);
        fwd_b = fwd(rt, readData2);
        op_b  = aluSrc ? signExtendWire : fwd_b;
    end

    // Decode, ALU and issue control
    always_comb begin
        fn        = decode_alu(aluOp, signExtendWire[5:0]);
        sa        = op_a;
        sb        = op_b;
        issue     = !stall;
        is_md     = (fn == ALU_MULT) || (fn == ALU_DIV);
        bubble    = !issue || flush || is_md;
        start_mul = issue && !flush && (fn == ALU_MULT);
        start_div = issue && !flush && (fn == ALU_DIV);
        case (fn)
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (sa < sb)};
            ALU_MFHI: alu_res = hi;
            ALU_MFLO: alu_res = lo;
            default:  alu_res = op_a + op_b;
        endcase
    end

    // EX/MEM next value: real instruction or an all-zero bubble
    always_comb begin
        alu_result_d = '0;
        write_data_d = '0;
        write_reg_d  = '0;
        mem_ctl_d    = '0;
        wb_ctl_d     = '0;
        if (!bubble) begin
            alu_result_d = alu_res;
            write_data_d = fwd_b;
            write_reg_d  = regDest ? rd : rt;
            mem_ctl_d    = memControlInput;
            wb_ctl_d     = wbControlInput;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            write_reg_q  <= '0;
            mem_ctl_q    <= '0;
            wb_ctl_q     <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            write_reg_q  <= write_reg_d;
            mem_ctl_q    <= mem_ctl_d;
            wb_ctl_q     <= wb_ctl_d;
        end
    end

    mul_div_unit u_mul_div (
        .clock       (clock),
        .reset       (reset),
        .start_mul_i (start_mul),
        .start_div_i (start_div),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .busy_o      (stall),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    assign aluResult       = alu_result_q;
    assign writeData       = write_data_q;
    assign writeReg        = write_reg_q;
    assign memControlExMem = mem_ctl_q;
    assign wbControlExMem  = wb_ctl_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the execute stage.
module tb_ex_stage;

    logic        clock, reset, flush, regDest, aluSrc;
    logic [1:0]  aluOp;
    logic [2:0]  memControlInput;
    logic [1:0]  wbControlInput;
    logic [31:0] readData1, readData2, signExtendWire;
    logic [4:0]  rd, rt, rs;
    logic        exMemRegWrite, memWbRegWrite;
    logic [4:0]  exMemRd, memWbRd;
    logic [31:0] exMemAluFwd, memWbData;
    logic [31:0] aluResult, writeData;
    logic [4:0]  writeReg;
    logic [2:0]  memControlExMem;
    logic [1:0]  wbControlExMem;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_stall_left = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;

    ex_stage dut (
        .clock(clock), .reset(reset), .flush(flush), .regDest(regDest), .aluSrc(aluSrc),
        .aluOp(aluOp), .memControlInput(memControlInput), .wbControlInput(wbControlInput),
        .readData1(readData1), .readData2(readData2), .signExtendWire(signExtendWire),
        .rd(rd), .rt(rt), .rs(rs),
        .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemAluFwd(exMemAluFwd),
        .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
        .aluResult(aluResult), .writeData(writeData), .writeReg(writeReg),
        .memControlExMem(memControlExMem), .wbControlExMem(wbControlExMem), .stall(stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] r, input logic [31:0] v);
        if (exMemRegWrite && exMemRd == r && r != 0) return exMemAluFwd;
        if (memWbRegWrite && memWbRd == r && r != 0) return memWbData;
        return v;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (fn)
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
            6'h10:   return m_hi;
            6'h12:   return m_lo;
            default: return a + b;
        endcase
    endfunction

    task automatic ref_muldiv(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p;
        sa = a;
        sb = b;
        if (!is_div) begin
            p = longint'(sa) * longint'(sb);
            m_phi = p[63:32];
            m_plo = p[31:0];
        end else if (b == 0) begin
            m_plo = 32'hFFFF_FFFF;
            m_phi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_plo = 32'h8000_0000;
            m_phi = 32'h0;
        end else begin
            m_plo = sa / sb;
            m_phi = sa % sb;
        end
    endtask

    // One clock: check stall, predict EX/MEM, clock, compare, advance model
    task automatic step();
        logic [31:0] fa, fb, bop, e_res, e_wd;
        logic [4:0]  e_wr;
        logic [2:0]  e_mem;
        logic [1:0]  e_wb;
        bit          m_stall, md, isdiv, bub;
        m_stall = (m_stall_left > 0);
        chk("stall", stall, m_stall);
        fa    = ref_fwd(rs, readData1);
        fb    = ref_fwd(rt, readData2);
        bop   = aluSrc ? signExtendWire : fb;
        isdiv = (aluOp == 2'b10) && (signExtendWire[5:0] == 6'h1A);
        md    = isdiv || ((aluOp == 2'b10) && (signExtendWire[5:0] == 6'h18));
        bub   = m_stall || flush || md;
        e_res = bub ? 32'h0 : ref_alu(aluOp, signExtendWire[5:0], fa, bop);
        e_wd  = bub ? 32'h0 : fb;
        e_wr  = bub ? 5'h0 : (regDest ? rd : rt);
        e_mem = bub ? 3'h0 : memControlInput;
        e_wb  = bub ? 2'h0 : wbControlInput;
        if (!m_stall && !flush && md) ref_muldiv(isdiv, fa, bop);
        @(posedge clock);
        #1;
        chk("aluResult", aluResult, e_res);
        chk("writeData", writeData, e_wd);
        chk("writeReg", writeReg, e_wr);
        chk("memCtl", memControlExMem, e_mem);
        chk("wbCtl", wbControlExMem, e_wb);
        if (m_stall_left > 0) begin
            m_stall_left--;
            if (m_stall_left == 0) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (!flush && md) begin
            m_stall_left = 33;
        end
    endtask

    task automatic clear_inputs();
        flush = 0; regDest = 1; aluSrc = 0; aluOp = 2'b00;
        memControlInput = 3'b010; wbControlInput = 2'b10;
        readData1 = 0; readData2 = 0; signExtendWire = 0;
        rd = 5'd9; rt = 0; rs = 0;
        exMemRegWrite = 0; exMemRd = 0; exMemAluFwd = 0;
        memWbRegWrite = 0; memWbRd = 0; memWbData = 0;
    endtask

    task automatic set_rtype(input logic [5:0] fn);
        aluOp = 2'b10;
        aluSrc = 0;
        signExtendWire = {26'h0, fn};
    endtask

    // Step while stalled; returns the number of stall cycles seen (bounded)
    task automatic run_stall(output int n);
        n = 0;
        while (stall && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic rand_inputs();
        logic [5:0] fns [9];
        int pick;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12, 6'h3F, 6'h00};
        pick = $urandom_range(0, 99);
        flush = ($urandom_range(0, 9) == 0);
        regDest = $urandom_range(0, 1);
        aluSrc = $urandom_range(0, 1);
        aluOp = $urandom_range(0, 3);
        memControlInput = $urandom_range(0, 7);
        wbControlInput = $urandom_range(0, 3);
        readData1 = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom_range(0, 40) - 20);
        readData2 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        signExtendWire = $urandom;
        rd = $urandom_range(0, 31);
        rt = $urandom_range(0, 3);
        rs = $urandom_range(0, 3);
        exMemRegWrite = $urandom_range(0, 1);
        exMemRd = $urandom_range(0, 3);
        exMemAluFwd = $urandom;
        memWbRegWrite = $urandom_range(0, 1);
        memWbRd = $urandom_range(0, 3);
        memWbData = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        if (pick < 4) set_rtype((pick < 2) ? 6'h18 : 6'h1A);
        else if (aluOp == 2'b10) set_rtype(fns[$urandom_range(0, 8)]);
    endtask

    initial begin
        int n;
        clear_inputs();
        reset = 1;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_alu", aluResult, 0);
        chk("rst_wreg", writeReg, 0);
        chk("rst_wb", wbControlExMem, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 0;

        // EX/MEM forwarding on A, register B
        clear_inputs();
        rs = 3; readData1 = 5; exMemRegWrite = 1; exMemRd = 3; exMemAluFwd = 10;
        rt = 4; readData2 = 7;
        step();
        chk("fwd_exmem_add", aluResult, 17);

        // EX/MEM beats MEM/WB; register 0 never forwarded
        clear_inputs();
        exMemRd = 3; memWbRd = 3; exMemRegWrite = 1; memWbRegWrite = 1;
        exMemAluFwd = 1; memWbData = 2; aluOp = 2'b01; rs = 3; rt = 0; readData2 = 0;
        step();
        chk("fwd_priority_sub", aluResult, 1);
        rs = 0; readData1 = 9;
        step();
        chk("fwd_r0_none", aluResult, 9);

        // mult 7 * -3
        clear_inputs();
        set_rtype(6'h18); rs = 1; rt = 2; readData1 = 7; readData2 = 32'hFFFF_FFFD;
        step();
        set_rtype(6'h12);
        run_stall(n);
        chk("mul_stall_len", n, 33);
        step();
        chk("mflo_mul", aluResult, 32'hFFFF_FFEB);
        set_rtype(6'h10);
        step();
        chk("mfhi_mul", aluResult, 32'hFFFF_FFFF);

        // divisions: 17/5, -17/5, 9/0
        begin
            logic [31:0] da [3], db [3], elo [3], ehi [3];
            da  = '{32'd17, 32'hFFFF_FFEF, 32'd9};
            db  = '{32'd5, 32'd5, 32'd0};
            elo = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
            ehi = '{32'd2, 32'hFFFF_FFFE, 32'd9};
            for (int i = 0; i < 3; i++) begin
                clear_inputs();
                set_rtype(6'h1A); rs = 1; rt = 2; readData1 = da[i]; readData2 = db[i];
                step();
                set_rtype(6'h12);
                run_stall(n);
                chk("div_stall_len", n, 33);
                step();
                chk("div_lo", aluResult, elo[i]);
                set_rtype(6'h10);
                step();
                chk("div_hi", aluResult, ehi[i]);
            end
        end

        // flush on mult issue: nothing starts, bubble loaded
        clear_inputs();
        memControlInput = 3'b101; wbControlInput = 2'b11;
        set_rtype(6'h18); rs = 1; rt = 2; readData1 = 3; readData2 = 4; flush = 1;
        step();
        chk("flush_mul_nostall", stall, 0);
        chk("flush_mul_bubble", wbControlExMem, 0);

        // flush during DIV is ignored
        clear_inputs();
        set_rtype(6'h1A); rs = 1; rt = 2; readData1 = 100; readData2 = 7;
        step();
        flush = 1;
        run_stall(n);
        chk("flush_div_stall_len", n, 33);
        flush = 0;
        set_rtype(6'h12);
        step();
        chk("flush_div_lo", aluResult, 14);

        // reset in the 10th MUL cycle aborts, clears HI/LO
        clear_inputs();
        set_rtype(6'h18); rs = 1; rt = 2; readData1 = 32'h1234; readData2 = 32'h5678;
        step();
        set_rtype(6'h10);
        for (int i = 0; i < 9; i++) step();
        #3;
        reset = 1;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_alu", aluResult, 0);
        @(posedge clock); #1;
        reset = 0;
        m_stall_left = 0; m_hi = 0; m_lo = 0;
        step();
        chk("midrst_mfhi", aluResult, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
